// File: rtl/watchdog_timer_unit.sv
// Heartbeat watchdog: counts enabled cycles since the last heartbeat, warns near
// the deadline and raises a sticky trip flag at timeout or on force_reset.
module watchdog_timer_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned WARN_CYCLES    = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        heartbeat,
  input  logic        force_reset,
  output logic [31:0] counter,
  output logic        warning,
  output logic        triggered
);

  localparam logic [31:0] TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] WARN_VAL    = 32'(WARN_CYCLES);

  logic [31:0] count_inc;
  logic [31:0] count_nxt;
  logic        warn_nxt;
  logic        trip_nxt;

  // Saturating increment; compare first so counter+1 never wraps at 2^32-1.
  always_comb begin
    count_inc = counter;
    if (heartbeat)
      count_inc = '0;
    else if (counter < TIMEOUT_VAL)
      count_inc = counter + 32'd1;
  end

  always_comb begin
    count_nxt = counter;
    warn_nxt  = warning;
    trip_nxt  = triggered;
    if (!enable) begin
      count_nxt = '0;
      warn_nxt  = 1'b0;
      trip_nxt  = 1'b0;
    end else if (force_reset) begin
      warn_nxt  = 1'b0;
      trip_nxt  = 1'b1;
    end else if (!triggered) begin
      count_nxt = count_inc;
      warn_nxt  = (count_inc >= WARN_VAL) && (count_inc < TIMEOUT_VAL);
      trip_nxt  = (count_inc >= TIMEOUT_VAL);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counter   <= '0;
      warning   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      counter   <= count_nxt;
      warning   <= warn_nxt;
      triggered <= trip_nxt;
    end
  end

endmodule

// File: tb/tb_watchdog_timer_unit.sv
// Directed bench for watchdog_timer_unit with the default 16/12 thresholds.
module tb_watchdog_timer_unit;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        heartbeat;
  logic        force_reset;
  logic [31:0] counter;
  logic        warning;
  logic        triggered;

  int n_vec;
  int n_err;

  watchdog_timer_unit #(.TIMEOUT_CYCLES(16), .WARN_CYCLES(12)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .heartbeat   (heartbeat),
    .force_reset (force_reset),
    .counter     (counter),
    .warning     (warning),
    .triggered   (triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] c, input logic w, input logic t);
    chk({tag, ".cnt"},  counter, c);
    chk({tag, ".warn"}, 32'(warning), 32'(w));
    chk({tag, ".trip"}, 32'(triggered), 32'(t));
  endtask

  initial begin
    int exp_c;
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0; enable = 1'b0; heartbeat = 1'b0; force_reset = 1'b0;

    step(2);
    chk_all("reset", 0, 0, 0);

    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk_all("idle", 0, 0, 0);
    end

    // Free-run to timeout
    enable = 1'b1;
    step(11);
    chk_all("run11", 11, 0, 0);
    step(1);
    chk_all("run12", 12, 1, 0);
    step(3);
    chk_all("run15", 15, 1, 0);
    step(1);
    chk_all("run16", 16, 0, 1);
    step(4);
    chk_all("run20", 16, 0, 1);

    // Clear via enable
    enable = 1'b0;
    step(1);
    chk_all("en_clr", 0, 0, 0);
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk("en_resume", counter, 32'(k));
    end

    // Force trip at counter=3, then heartbeats are ignored
    force_reset = 1'b1;
    step(1);
    chk_all("force", 3, 0, 1);
    force_reset = 1'b0;
    heartbeat = 1'b1;
    step(3);
    chk_all("force_hb", 3, 0, 1);
    heartbeat = 1'b0;

    // Async reset mid-trip
    rstn = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0);
    step(1);
    rstn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk("rst_resume", counter, 32'(k));
    end

    // Heartbeat at counter=15 wins over the approaching deadline
    step(12);
    chk_all("pre_hb15", 15, 1, 0);
    heartbeat = 1'b1;
    step(1);
    chk_all("hb15", 0, 0, 0);
    heartbeat = 1'b0;

    // Periodic heartbeat service
    exp_c = 0;
    for (int i = 0; i < 100; i++) begin
      heartbeat = ((i % 10) == 9);
      step(1);
      exp_c = heartbeat ? 0 : exp_c + 1;
      chk_all("svc", 32'(exp_c), 0, 0);
    end

    // Held heartbeat pins counter at zero
    heartbeat = 1'b1;
    step(20);
    chk_all("hb_held", 0, 0, 0);

    // Heartbeat and force on the same edge: force wins
    force_reset = 1'b1;
    step(1);
    chk_all("hb_force", 0, 0, 1);
    force_reset = 1'b0;
    heartbeat = 1'b0;
    enable = 1'b0;
    step(1);
    chk_all("clr2", 0, 0, 0);

    // Mid-count reset then full run
    enable = 1'b1;
    step(14);
    chk_all("mid14", 14, 1, 0);
    rstn = 1'b0;
    step(1);
    chk_all("mid_rst", 0, 0, 0);
    rstn = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step(1);
      chk_all("post_rst", 32'((k < 16) ? k : 16), (k >= 12) && (k < 16), k >= 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
